// File: rtl/edge_det_pkg.sv
// edge_det_pkg: mode encodings, limits and the mode-match helper shared by the edge detector files.
package edge_det_pkg;
  typedef enum logic [1:0] {
    MODE_OFF  = 2'b00,
    MODE_RISE = 2'b01,
    MODE_FALL = 2'b10,
    MODE_BOTH = 2'b11
  } mode_e;
  localparam int MAX_SYNC = 4;
  localparam int MAX_FILT = 15;
  function automatic logic edge_hit(input logic [1:0] mode, input logic rise, input logic fall);
    return (rise && (mode == MODE_RISE || mode == MODE_BOTH)) ||
           (fall && (mode == MODE_FALL || mode == MODE_BOTH));
  endfunction
endpackage

// File: rtl/edge_det_chan.sv
// edge_det_chan: one channel -- synchroniser, optional glitch filter (MED_FILTER_EN), edge pulses, sticky pending.
module edge_det_chan
  import edge_det_pkg::*;
#(
  parameter int SYNC_STAGES = 2
`ifdef MED_FILTER_EN
  ,
  parameter int FILT_CYCLES = 3
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sig,
  input  logic [1:0] mode,
  input  logic       clr,
  input  logic       en,
  output logic       level,
  output logic       pos_pulse,
  output logic       neg_pulse,
  output logic       pending
);
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic level_q, level_d, prev_q, prev_d, pos_q, pos_d, neg_q, neg_d, pend_q, pend_d;
  logic samp, filt, rise, fall;
  assign samp = sync_q[SYNC_STAGES-1];
`ifdef MED_FILTER_EN
  localparam logic [3:0] FILT_LAST = 4'(FILT_CYCLES - 1);
  logic       filt_q, filt_d;
  logic [3:0] cnt_q, cnt_d;
  // filt flips on the FILT_CYCLES-th consecutive differing sample; any agreeing sample restarts the count
  always_comb begin
    filt_d = (samp != filt_q && cnt_q == FILT_LAST) ? samp : filt_q;
    cnt_d  = (samp == filt_q || cnt_q == FILT_LAST) ? 4'd0 : cnt_q + 4'd1;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      filt_q <= 1'b0;
      cnt_q  <= 4'd0;
    end else begin
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
    end
  end
  assign filt = filt_q;
`else
  assign filt = samp;
`endif
  assign rise = level_q & ~prev_q;
  assign fall = ~level_q & prev_q;
  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], sig};
    level_d = filt;
    prev_d  = level_q;
    pos_d   = en & rise;
    neg_d   = en & fall;
    pend_d  = (en & edge_hit(mode, rise, fall)) | (pend_q & ~clr);
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q  <= '0;
      level_q <= 1'b0;
      prev_q  <= 1'b0;
      pos_q   <= 1'b0;
      neg_q   <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      level_q <= level_d;
      prev_q  <= prev_d;
      pos_q   <= pos_d;
      neg_q   <= neg_d;
      pend_q  <= pend_d;
    end
  end
  assign level     = level_q;
  assign pos_pulse = pos_q;
  assign neg_pulse = neg_q;
  assign pending   = pend_q;
endmodule

// File: rtl/multi_edge_detector.sv
// multi_edge_detector: N-channel synchronising edge detector with pulses, W1C pending and masked irq.
// Optional glitch filter enabled by defining MED_FILTER_EN.
module multi_edge_detector
  import edge_det_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CYCLES = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_CH-1:0]   sig,
  input  logic [2*N_CH-1:0] mode,
  input  logic [N_CH-1:0]   irq_mask,
  input  logic [N_CH-1:0]   clr,
  output logic [N_CH-1:0]   level,
  output logic [N_CH-1:0]   pos_pulse,
  output logic [N_CH-1:0]   neg_pulse,
  output logic [N_CH-1:0]   pending,
  output logic              irq
);
  if (N_CH < 1 || N_CH > 32) begin : g_bad_nch
    $error("N_CH out of range");
  end
  if (SYNC_STAGES < 2 || SYNC_STAGES > MAX_SYNC) begin : g_bad_sync
    $error("SYNC_STAGES out of range");
  end
  if (FILT_CYCLES < 1 || FILT_CYCLES > MAX_FILT) begin : g_bad_filt
    $error("FILT_CYCLES out of range");
  end
  // suppression window covers the whole pipeline up to the first edge compare, so a level held through reset never looks like a rise
`ifdef MED_FILTER_EN
  localparam logic [4:0] WARM = 5'(SYNC_STAGES + 2 + FILT_CYCLES);
`else
  localparam logic [4:0] WARM = 5'(SYNC_STAGES + 2);
`endif
  logic [4:0] warm_q, warm_d;
  logic       irq_q, irq_d;
  logic       en;
  assign en = (warm_q == WARM);
  always_comb begin
    warm_d = en ? warm_q : warm_q + 5'd1;
    irq_d  = |(pending & irq_mask);
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      warm_q <= 5'd0;
      irq_q  <= 1'b0;
    end else begin
      warm_q <= warm_d;
      irq_q  <= irq_d;
    end
  end
  assign irq = irq_q;
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    edge_det_chan #(
      .SYNC_STAGES(SYNC_STAGES)
`ifdef MED_FILTER_EN
      ,
      .FILT_CYCLES(FILT_CYCLES)
`endif
    ) u_chan (
      .clk      (clk),
      .reset    (reset),
      .sig      (sig[i]),
      .mode     (mode[2*i+:2]),
      .clr      (clr[i]),
      .en       (en),
      .level    (level[i]),
      .pos_pulse(pos_pulse[i]),
      .neg_pulse(neg_pulse[i]),
      .pending  (pending[i])
    );
  end
endmodule

// File: tb/tb_multi_edge_detector.sv
// tb_multi_edge_detector: scoreboard bench; expected pulses are queued at stimulus time and popped by a monitor.
module tb_multi_edge_detector;
  localparam int FILT = 3;
`ifdef MED_FILTER_EN
  localparam int DLY = 4 + FILT;
`else
  localparam int DLY = 4;
`endif
  typedef struct {
    int         cyc;
    logic [3:0] pos;
    logic [3:0] neg;
  } exp_t;
  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] sig, irq_mask, clr, level, pos_pulse, neg_pulse, pending;
  logic [7:0] mode;
  logic       irq;
  int         cyc = 0;
  int         errors = 0;
  int         checks = 0;
  exp_t       sbq[$];
  multi_edge_detector #(.N_CH(4), .SYNC_STAGES(2), .FILT_CYCLES(FILT)) dut (
    .clk      (clk),
    .reset    (reset),
    .sig      (sig),
    .mode     (mode),
    .irq_mask (irq_mask),
    .clr      (clr),
    .level    (level),
    .pos_pulse(pos_pulse),
    .neg_pulse(neg_pulse),
    .pending  (pending),
    .irq      (irq)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic set_sig(input logic [3:0] v);
    logic [3:0] p, n;
    p = v & ~sig;
    n = ~v & sig;
    if ((p | n) != 4'd0) sbq.push_back('{cyc + DLY, p, n});
    sig = v;
  endtask
  always @(negedge clk) begin
    if (reset === 1'b1 && (pos_pulse | neg_pulse) != 4'd0) begin
      exp_t e;
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got pos=%b neg=%b at cyc %0d, required no pulse", pos_pulse, neg_pulse, cyc);
      end else begin
        e = sbq.pop_front();
        if (e.cyc != cyc || e.pos !== pos_pulse || e.neg !== neg_pulse) begin
          errors++;
          $display("FAIL sb_pulse: got pos=%b neg=%b at cyc %0d, required pos=%b neg=%b at cyc %0d",
                   pos_pulse, neg_pulse, cyc, e.pos, e.neg, e.cyc);
        end
      end
    end
  end
  initial begin
    reset = 1'b0; sig = 4'hF; mode = 8'h00; irq_mask = 4'h0; clr = 4'h0;
    tick(3);
    chk("rst_level", level, 0);
    chk("rst_pend", pending, 0);
    chk("rst_irq", irq, 0);
    chk("rst_pulse", {pos_pulse, neg_pulse}, 0);
    reset = 1'b1;
    tick(12);
    chk("warm_level", level, 4'hF);
    chk("warm_pend", pending, 0);
    chk("warm_irq", irq, 0);
    mode = 8'b0000_0001; irq_mask = 4'b0001;
    set_sig(4'b1110); tick(12);
    chk("t2_fall_nopend", pending, 0);
    set_sig(4'b1111); tick(DLY);
    chk("t2_pend", pending, 4'b0001);
    chk("t2_irq_lag", irq, 0);
    tick(1);
    chk("t2_irq", irq, 1);
    tick(8);
    set_sig(4'b1110); tick(12);
    chk("t3_fall_keeps", pending, 4'b0001);
    set_sig(4'b1111); tick(DLY - 1);
    clr = 4'b0001; tick(1); clr = 4'b0000;
    chk("t3_set_wins", pending, 4'b0001);
    tick(5);
    clr = 4'b0001; tick(1); clr = 4'b0000;
    chk("t3_clr", pending, 0);
    chk("t3_irq_hold", irq, 1);
    tick(1);
    chk("t3_irq_fall", irq, 0);
    set_sig(4'b1101); tick(12);
    chk("t4_off_nopend", pending, 0);
    mode = 8'b0000_1001;
    set_sig(4'b1111); tick(DLY);
    chk("t4_rise_nopend", pending, 0);
    tick(8);
    set_sig(4'b1101); tick(DLY);
    chk("t4_fall_pend", pending, 4'b0010);
    tick(8);
`ifdef MED_FILTER_EN
    set_sig(4'b1001); tick(12);
    sig = 4'b1101; tick(2); sig = 4'b1001; tick(12);
    chk("t5_glitch_level", level, 4'b1001);
    set_sig(4'b1101); tick(5); set_sig(4'b1001); tick(12 + DLY);
    chk("t5_level", level, 4'b1001);
`endif
    mode = 8'hFF; irq_mask = 4'hF;
    set_sig(~sig); tick(DLY);
    chk("t6_pend_all", pending, 4'hF);
    tick(1);
    chk("t6_irq", irq, 1);
    #2 reset = 1'b0;
    #1;
    chk("t6_async_pend", pending, 0);
    chk("t6_async_irq", irq, 0);
    chk("t6_async_level", level, 0);
    chk("t6_async_pulse", {pos_pulse, neg_pulse}, 0);
    tick(2);
    reset = 1'b1;
    tick(15);
    chk("t6_post_level", level, {28'd0, sig});
    chk("t6_post_pend", pending, 0);
    chk("t6_post_irq", irq, 0);
    chk("sb_drained", sbq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
